fifo_senior: RTL
================

Name: fifo_senior

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the 8-bit fifo_junior buffer and uses the same write/read/fifo_empty/fifo_full handshake. It adds:
- configurable width and depth
- fill count
- almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- optional first-word-fall-through (FWFT) read mode

It sits between a byte/word producer and consumer in the same clock domain.

Parameters:
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries. Power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL. Range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (data one cycle after read); 1 = head word visible on data_out while not empty.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- write  in  1  push request; data_in sampled on the same edge.
- read  in  1  pop request.
- data_in  in  DATA_W  write data.
- err_clr  in  1  clears overflow and underflow.
- data_out  out  DATA_W  read data.
- fifo_empty  out  1  high when count == 0.
- fifo_full  out  1  high when count == DEPTH.
- almost_full  out  1  high when count ≥ AF_LEVEL.
- almost_empty  out  1  high when count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- overflow  out  1  sticky; set when a write is dropped.
- underflow  out  1  sticky; set when a read is ignored.

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1
  - almost_full = 0 (1 only if AF_LEVEL == 0, which is illegal)
  - overflow = underflow = 0, data_out = 0
  - Memory contents are not cleared.
- Reset has priority over all other inputs. When rst_i is asserted mid-operation, all stored words are discarded on that edge.
- Accepted write: write = 1 and (!fifo_full or read accepted in the same cycle). Effect: mem[wr_ptr] <= data_in, wr_ptr increments.
- Accepted read: read = 1 and !fifo_empty. Effect: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered and consistent with count on the same cycle (zero-cycle flag lag relative to count).
- Simultaneous read + write:
  - When empty: the write is accepted, the read is ignored and sets underflow. count becomes 1.
  - When full: both are accepted, count stays DEPTH, and the oldest word is output.
  - Otherwise: both are accepted and count is unchanged.
- Write when full with no read: the word is dropped, pointers and count are unchanged, and overflow <= 1.
- Read when empty: no state change except underflow <= 1.
- err_clr: clears overflow and underflow on the next edge. If a new error occurs in the same cycle, the set wins over the clear.
- FWFT = 0:
  - On an accepted read, data_out <= mem[rd_ptr] (valid the cycle after read is sampled).
  - data_out holds its value otherwise, including on ignored reads.
- FWFT = 1:
  - data_out = mem[rd_ptr] when !fifo_empty, else 0 (combinational from registered pointer).
  - The first written word appears on data_out one cycle after its write edge.
  - An accepted read advances to the next word.
- Memory uses synchronous write and is inferable as RAM. There is no reset on mem.

Test Plan:
1. Fill and overflow: after reset (DEPTH=16, DATA_W=8, FWFT=0), write 3..18 on consecutive cycles, then write 19.
   - count reaches 16 and fifo_full = 1 after the 16th write.
   - almost_full rises when count = 14.
   - The write of 19 is dropped and overflow = 1.
   - Then read 16 times: data_out = 3..18, each one cycle after its read. fifo_empty = 1 after the 16th read.
2. Underflow and clear: read while empty, then assert err_clr for one cycle.
   - underflow = 1 and count = 0, data_out unchanged.
   - err_clr returns underflow to 0.
3. Simultaneous at boundaries:
   - Empty + read + write(0xA5): count = 1, underflow = 1.
   - Full + read + write(0x55): count stays 16, the oldest word is output, 0x55 is later read last. overflow stays 0.
4. Wrap-around: 50 cycles of concurrent read + write with incrementing data, starting from count = 5.
   - count stays 5 throughout.
   - The read sequence is strictly in write order across pointer wrap.
5. Reset mid-operation: assert rst_i with count = 9 and a write pending.
   - Next cycle: count = 0, fifo_empty = 1, flags cleared, data_out = 0, and the pending write is discarded.
6. FWFT = 1: write 0x11 then 0x22.
   - data_out = 0x11 one cycle after the first write, with no read issued.
   - read → data_out = 0x22.
   - read → fifo_empty = 1, data_out = 0.

Source files
------------

// File: rtl/fifo_senior.sv
// fifo_senior: parametrised single-clock FIFO with fill count, thresholds, sticky errors and optional FWFT
// Ports: clk_i/rst_i clock and sync active-high reset; write/read push and pop requests;
// data_in write data; err_clr clears the sticky flags; data_out read data;
// fifo_empty/fifo_full/almost_full/almost_empty status; count stored words;
// overflow/underflow sticky drop/ignore flags.
module fifo_senior #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       write,
    input  logic                       read,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          data_out,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_empty, r_full, r_af, r_ae, r_ovf, r_udf;
    logic              w_rd, w_wr;
    logic [CW-1:0]     w_cnt_nxt;

    // a write into a full FIFO is still accepted when a read frees the slot on the same edge
    always_comb begin
        w_rd      = read && !r_empty;
        w_wr      = write && (!r_full || w_rd);
        w_cnt_nxt = (w_wr && !w_rd) ? r_count + 1'b1 :
                    (w_rd && !w_wr) ? r_count - 1'b1 : r_count;
    end

    always_ff @(posedge clk_i)
        if (w_wr && !rst_i)
            r_mem[r_wr_ptr] <= data_in;

    // flags are computed from the next count so they never lag count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= (AF_C == '0);
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == FULL_C);
            r_af    <= (w_cnt_nxt >= AF_C);
            r_ae    <= (w_cnt_nxt <= AE_C);
            r_ovf   <= (write && !w_wr) || (r_ovf && !err_clr);
            r_udf   <= (read && r_empty) || (r_udf && !err_clr);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
        logic [DATA_W-1:0] r_dout;
        always_ff @(posedge clk_i)
            if (rst_i)
                r_dout <= '0;
            else if (w_rd)
                r_dout <= r_mem[r_rd_ptr];
        assign data_out = r_dout;
    end

    assign fifo_empty   = r_empty;
    assign fifo_full    = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
endmodule
